// File: rtl/bullet_bill_controller.sv
// BulletBill projectile controller: three slots, frame-paced movement,
// hit detection against the DDAVER grid and cooldown-gated spawning.
module bullet_bill_controller #(
  parameter int MOVE_FRAMES     = 4,
  parameter int SPAWN_COL       = 2,
  parameter int LAST_COL        = 15,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        frameTick,
  input  logic        fire,
  input  logic [11:0] fireColor,
  input  logic [3:0]  blockieee,
  input  logic [11:0] ddavers [0:4][0:5],
  output logic [11:0] bulletBillColor [0:2],
  output logic [3:0]  bulletBillXLoc [0:2],
  output logic [3:0]  bulletBillYLoc [0:2],
  output logic        fireAccepted,
  output logic        hitValid,
  output logic [2:0]  hitRow,
  output logic [2:0]  hitCol,
  output logic        hitMatch,
  output logic [2:0]  fsmState
);

  localparam int FCW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, MOVE, CHECK0, CHECK1, CHECK2, SPAWN} state_t;

  state_t         state;
  logic [FCW-1:0] frameCnt;
  logic [CDW-1:0] cooldown;
  logic           pendingFire;
  logic [11:0]    pendColor;
  logic [3:0]     pendRow;

  logic [1:0]  chkIdx;
  logic [11:0] chkColor;
  logic [3:0]  chkX;
  logic [3:0]  chkY;
  logic        inRange;
  logic [2:0]  rowIdx;
  logic [2:0]  colIdx;
  logic [11:0] enemy;
  logic        hit;
  logic [1:0]  freeIdx;
  logic        freeAvail;
  logic [11:0] spawnColor;
  logic [3:0]  spawnRow;
  logic        spawnOk;

  assign fsmState = state;

  always_comb begin
    case (state)
      CHECK1:  chkIdx = 2'd1;
      CHECK2:  chkIdx = 2'd2;
      default: chkIdx = 2'd0;
    endcase
    chkColor = bulletBillColor[chkIdx];
    chkX     = bulletBillXLoc[chkIdx];
    chkY     = bulletBillYLoc[chkIdx];
    // Only odd rows 1..9 and even columns 4..14 overlay an enemy cell.
    inRange  = (chkColor != 12'd0) && chkY[0] && (chkY <= 4'd9) &&
               !chkX[0] && (chkX >= 4'd4) && (chkX <= 4'd14);
    rowIdx   = inRange ? chkY[3:1] : 3'd0;
    colIdx   = inRange ? (chkX[3:1] - 3'd2) : 3'd0;
    enemy    = ddavers[rowIdx][colIdx];
    hit      = inRange && (enemy != 12'd0);

    freeIdx   = 2'd0;
    freeAvail = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (bulletBillColor[i] == 12'd0) begin
        freeIdx   = 2'(i);
        freeAvail = 1'b1;
      end
    end

    // A fire arriving in the SPAWN cycle itself is consumed there.
    spawnColor = fire ? fireColor : pendColor;
    spawnRow   = fire ? blockieee : pendRow;
    spawnOk    = (pendingFire || fire) && (cooldown == '0) &&
                 (spawnColor != 12'd0) && (spawnRow <= 4'd10) && freeAvail;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      frameCnt     <= '0;
      cooldown     <= '0;
      pendingFire  <= 1'b0;
      pendColor    <= 12'd0;
      pendRow      <= 4'd0;
      fireAccepted <= 1'b0;
      hitValid     <= 1'b0;
      hitRow       <= 3'd0;
      hitCol       <= 3'd0;
      hitMatch     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        bulletBillColor[i] <= 12'd0;
        bulletBillXLoc[i]  <= 4'd0;
        bulletBillYLoc[i]  <= 4'd0;
      end
    end else begin
      fireAccepted <= 1'b0;
      hitValid     <= 1'b0;
      if (fire) begin
        pendingFire <= 1'b1;
        pendColor   <= fireColor;
        pendRow     <= blockieee;
      end
      case (state)
        IDLE: if (frameTick) state <= MOVE;
        MOVE: begin
          if (frameCnt == FCW'(MOVE_FRAMES - 1)) begin
            frameCnt <= '0;
            for (int i = 0; i < 3; i++) begin
              if (bulletBillColor[i] != 12'd0) begin
                if (bulletBillXLoc[i] < 4'(LAST_COL)) begin
                  bulletBillXLoc[i] <= bulletBillXLoc[i] + 4'd1;
                end else begin
                  bulletBillColor[i] <= 12'd0;
                  bulletBillXLoc[i]  <= 4'd0;
                  bulletBillYLoc[i]  <= 4'd0;
                end
              end
            end
          end else begin
            frameCnt <= frameCnt + FCW'(1);
          end
          if (cooldown != '0) cooldown <= cooldown - CDW'(1);
          state <= CHECK0;
        end
        CHECK0, CHECK1, CHECK2: begin
          if (hit) begin
            hitValid                <= 1'b1;
            hitRow                  <= rowIdx;
            hitCol                  <= colIdx;
            hitMatch                <= (chkColor == enemy);
            bulletBillColor[chkIdx] <= 12'd0;
            bulletBillXLoc[chkIdx]  <= 4'd0;
            bulletBillYLoc[chkIdx]  <= 4'd0;
          end
          case (state)
            CHECK0:  state <= CHECK1;
            CHECK1:  state <= CHECK2;
            default: state <= SPAWN;
          endcase
        end
        SPAWN: begin
          pendingFire <= 1'b0;
          if (spawnOk) begin
            bulletBillColor[freeIdx] <= spawnColor;
            bulletBillXLoc[freeIdx]  <= 4'(SPAWN_COL);
            bulletBillYLoc[freeIdx]  <= spawnRow;
            fireAccepted             <= 1'b1;
            cooldown                 <= CDW'(COOLDOWN_FRAMES);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_bill_controller.sv
// Directed bench for bullet_bill_controller: slot contents checked after each
// frame sequence, fireAccepted/hitValid events checked against a queue.
module tb_bullet_bill_controller;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        frameTick = 1'b0;
  logic        fire = 1'b0;
  logic [11:0] fireColor = 12'd0;
  logic [3:0]  blockieee = 4'd0;
  logic [11:0] ddavers [0:4][0:5];
  logic [11:0] bulletBillColor [0:2];
  logic [3:0]  bulletBillXLoc [0:2];
  logic [3:0]  bulletBillYLoc [0:2];
  logic        fireAccepted;
  logic        hitValid;
  logic [2:0]  hitRow;
  logic [2:0]  hitCol;
  logic        hitMatch;
  logic [2:0]  fsmState;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_got;
  logic [7:0] mon_exp;

  // Event encoding: accept = 8'h00, hit = {1, row, col, match}.
  localparam logic [7:0] EV_ACCEPT = 8'h00;

  bullet_bill_controller dut (
    .clk(clk), .rstN(rstN), .frameTick(frameTick), .fire(fire),
    .fireColor(fireColor), .blockieee(blockieee), .ddavers(ddavers),
    .bulletBillColor(bulletBillColor), .bulletBillXLoc(bulletBillXLoc),
    .bulletBillYLoc(bulletBillYLoc), .fireAccepted(fireAccepted),
    .hitValid(hitValid), .hitRow(hitRow), .hitCol(hitCol),
    .hitMatch(hitMatch), .fsmState(fsmState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_slot(input int i, input logic [11:0] c, input logic [3:0] x, input logic [3:0] y);
    check($sformatf("slot%0d", i),
          {bulletBillColor[i], bulletBillXLoc[i], bulletBillYLoc[i]}, {c, x, y});
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) check_slot(i, 12'd0, 4'd0, 4'd0);
    check({tag, "_flags"}, {fireAccepted, hitValid, hitRow, hitCol, hitMatch}, 0);
    check({tag, "_state"}, fsmState, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstN = 1'b1;
  endtask

  task automatic clear_ddavers();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++) ddavers[r][c] = 12'd0;
  endtask

  // ---------------- driver ----------------
  // One frame: frameTick (optionally with fire), then wait out the 6-cycle sequence.
  task automatic do_frame(input logic f, input logic [11:0] c, input logic [3:0] r);
    @(posedge clk); #1;
    fire = f; fireColor = c; blockieee = r; frameTick = 1'b1;
    @(posedge clk); #1;
    fire = 1'b0; frameTick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rstN && (fireAccepted || hitValid)) begin
      mon_got = hitValid ? {1'b1, hitRow, hitCol, hitMatch} : EV_ACCEPT;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got %02h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", mon_got, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_ddavers();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    rstN = 1'b1;

    // A: spawn, cooldown rejection, accept at frame 9, hit at X=6.
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'hF00, 4'd3);                 // frame 1
    check_slot(0, 12'hF00, 4'd2, 4'd3);
    check_slot(1, 12'd0, 4'd0, 4'd0);
    check_slot(2, 12'd0, 4'd0, 4'd0);
    do_frame(1'b1, 12'h0F0, 4'd5);                 // frame 2: cooldown 7
    check_slot(1, 12'd0, 4'd0, 4'd0);
    for (int f = 3; f <= 7; f++) do_frame(1'b0, 12'd0, 4'd0);
    do_frame(1'b1, 12'h0F0, 4'd5);                 // frame 8: cooldown 1
    check_slot(1, 12'd0, 4'd0, 4'd0);
    check_slot(0, 12'hF00, 4'd4, 4'd3);
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'h0F0, 4'd5);                 // frame 9: cooldown 0
    check_slot(1, 12'h0F0, 4'd2, 4'd5);
    check_slot(0, 12'hF00, 4'd4, 4'd3);
    ddavers[1][1] = 12'hF00;
    for (int f = 10; f <= 16; f++) begin
      if (f == 16) exp_q.push_back({1'b1, 3'd1, 3'd1, 1'b1});
      do_frame(1'b0, 12'd0, 4'd0);
      if (f == 12) check_slot(0, 12'hF00, 4'd5, 4'd3);
    end
    check_slot(0, 12'd0, 4'd0, 4'd0);
    check_slot(1, 12'h0F0, 4'd4, 4'd5);

    // B: colour-0 and row-11 rejections, row-10 accept, full movement.
    clear_ddavers();
    do_reset();
    do_frame(1'b1, 12'h000, 4'd3);                 // frame 1
    check_slot(0, 12'd0, 4'd0, 4'd0);
    do_frame(1'b1, 12'hF00, 4'd11);                // frame 2
    check_slot(0, 12'd0, 4'd0, 4'd0);
    do_frame(1'b0, 12'd0, 4'd0);                   // frame 3
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'h00F, 4'd10);                // frame 4
    check_slot(0, 12'h00F, 4'd2, 4'd10);
    for (int k = 1; k <= 56; k++) begin
      do_frame(1'b0, 12'd0, 4'd0);
      if (k == 3)  check_slot(0, 12'h00F, 4'd2, 4'd10);
      if (k == 4)  check_slot(0, 12'h00F, 4'd3, 4'd10);
      if (k == 52) check_slot(0, 12'h00F, 4'd15, 4'd10);
      if (k == 55) check_slot(0, 12'h00F, 4'd15, 4'd10);
      if (k == 56) check_slot(0, 12'd0, 4'd0, 4'd0);
    end

    // C: fill all slots, reject when full, dual hit, reset during CHECK1.
    do_reset();
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'hF00, 4'd1);                 // frame 1 -> slot0
    for (int f = 2; f <= 8; f++) do_frame(1'b0, 12'd0, 4'd0);
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'h0F0, 4'd7);                 // frame 9 -> slot1
    for (int f = 10; f <= 16; f++) do_frame(1'b0, 12'd0, 4'd0);
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'h00F, 4'd9);                 // frame 17 -> slot2
    check_slot(2, 12'h00F, 4'd2, 4'd9);
    for (int f = 18; f <= 24; f++) do_frame(1'b0, 12'd0, 4'd0);
    do_frame(1'b1, 12'hFFF, 4'd3);                 // frame 25: all full
    check_slot(0, 12'hF00, 4'd8, 4'd1);
    check_slot(1, 12'h0F0, 4'd6, 4'd7);
    check_slot(2, 12'h00F, 4'd4, 4'd9);
    for (int f = 26; f <= 29; f++) do_frame(1'b0, 12'd0, 4'd0);
    ddavers[0][3] = 12'hF00;
    ddavers[4][1] = 12'h0F0;
    do_frame(1'b0, 12'd0, 4'd0);                   // frame 30
    do_frame(1'b0, 12'd0, 4'd0);                   // frame 31
    exp_q.push_back({1'b1, 3'd0, 3'd3, 1'b1});
    exp_q.push_back({1'b1, 3'd4, 3'd1, 1'b0});
    do_frame(1'b0, 12'd0, 4'd0);                   // frame 32
    check_slot(0, 12'd0, 4'd0, 4'd0);
    check_slot(1, 12'h0F0, 4'd8, 4'd7);
    check_slot(2, 12'd0, 4'd0, 4'd0);

    ddavers[3][2] = 12'h0F0;                       // slot1 would hit in CHECK1
    @(posedge clk); #1;
    frameTick = 1'b1;
    @(posedge clk); #1;
    frameTick = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("state_before_abort", fsmState, 3);
    rstN = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("idle_after_abort", fsmState, 0);
    check("no_event_after_abort", exp_q.size(), 0);
    exp_q.push_back(EV_ACCEPT);
    do_frame(1'b1, 12'h0F0, 4'd3);
    check_slot(0, 12'h0F0, 4'd2, 4'd3);
    check_slot(1, 12'd0, 4'd0, 4'd0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bullet_bill_controller.md
Name: bullet_bill_controller

Overview:
- Owns the three BulletBill projectile slots and drives `bulletBillColor`, `bulletBillXLoc` and `bulletBillYLoc` into the graphics generator.
- Accepts fire requests from Blockieee and advances live bullets one 40-px cell to the right every MOVE_FRAMES frames.
- Detects hits against the DDAVER grid and reports each hit to the enemy-state owner.
- All state updates happen on a per-frame tick, so the display never tears mid-frame.

Parameters:
- MOVE_FRAMES, 4, number of frameTicks between one-cell advances (>=1).
- SPAWN_COL, 2, grid column where a new bullet appears (the column right of Blockieee).
- LAST_COL, 15, rightmost visible grid column (640/40 - 1).
- COOLDOWN_FRAMES, 8, frameTicks after an accepted fire during which new fires are rejected.

Ports:
- clk, input, 1, system clock.
- rstN, input, 1, asynchronous active-low reset.
- frameTick, input, 1, one-cycle pulse per frame (start of vertical blank).
- fire, input, 1, fire request pulse (any cycle).
- fireColor, input, 12, RGB444 colour of the requested bullet.
- blockieee, input, 4, Blockieee grid row.
- ddavers, input, 12 x [0:4][0:5], enemy colours; 0 means empty.
- bulletBillColor, output, 12 x [0:2], slot colour; 0 means inactive.
- bulletBillXLoc, output, 4 x [0:2], slot grid column.
- bulletBillYLoc, output, 4 x [0:2], slot grid row.
- fireAccepted, output, 1, one-cycle pulse when a bullet is spawned.
- hitValid, output, 1, one-cycle pulse per hit.
- hitRow, output, 3, ddavers first index of the hit.
- hitCol, output, 3, ddavers second index of the hit.
- hitMatch, output, 1, bullet colour equals enemy colour (valid with hitValid).

Behaviour:
- Reset (async, rstN=0):
  - All slot colour/X/Y = 0.
  - fireAccepted, hitValid, hitRow, hitCol, hitMatch = 0.
  - Frame counter, cooldown and fire-pending flag = 0.
  - FSM = IDLE.
- Reset mid-sequence aborts the sequence immediately with no partial spawn or hit.
- Fire capture:
  - fire=1 sets pendingFire and latches fireColor and blockieee (last request wins) on any cycle.
  - pendingFire clears only in SPAWN, accepted or rejected.
- FSM: IDLE -> MOVE -> CHECK0 -> CHECK1 -> CHECK2 -> SPAWN -> IDLE.
  - One state per cycle; a frameTick in IDLE starts the sequence.
  - A frameTick while not in IDLE is ignored.
- MOVE:
  - If frameCnt == MOVE_FRAMES-1: frameCnt <= 0 and every active slot advances.
    - X < LAST_COL: X <= X+1.
    - X == LAST_COL: slot freed (colour, X, Y <= 0).
  - Otherwise frameCnt <= frameCnt+1.
  - Cooldown decrements if nonzero.
- CHECKi (slot i), a hit requires all of:
  - slot active;
  - Y odd and Y <= 9;
  - X even and 4 <= X <= 14;
  - ddavers[Y/2][X/2-2] != 0.
- On a hit, in the following cycle:
  - hitValid=1, hitRow=Y/2, hitCol=X/2-2, hitMatch=(slot colour == enemy colour).
  - Slot freed.
- Multiple hits in one frame pulse on consecutive cycles in slot order.
- Two slots on the same cell both report.
- The controller never writes ddavers; the owner clears the enemy.
- SPAWN: accept only if all of the following hold:
  - pendingFire;
  - cooldown == 0;
  - latched colour != 0;
  - latched row <= 10 (row 11 is buffer);
  - a free slot exists.
- On accept:
  - Lowest-index free slot <= (colour, X=SPAWN_COL, Y=row).
  - fireAccepted pulses in the next cycle.
  - cooldown <= COOLDOWN_FRAMES.
- On reject: request dropped silently.
- fire in the same cycle as SPAWN: that request is consumed there; a fire one cycle later stays pending for the next frame.
- A spawned bullet is not moved or hit-checked until the next frame; spawn column 2 can never hit.
- Outputs change only in MOVE/CHECK/SPAWN, so they are stable for the whole visible frame.
- Sequence latency from frameTick to outputs final: 5 cycles.

Test Plan:
- Reset then fire(fireColor=12'hF00, blockieee=3) and frameTick -> after 5 cycles slot0=(F00, X=2, Y=3) and fireAccepted pulses once; slots 1-2 stay 0.
- MOVE_FRAMES=4, bullet at X=2, 56 further frameTicks -> X increments every 4th tick, reaches 15 after 52 ticks, then the slot is freed (colour 0) at tick 56.
- ddavers[1][1]=12'hF00, bullet F00 at row 3 moving right -> on the tick it enters X=6: hitValid=1, hitRow=1, hitCol=1, hitMatch=1; slot0 freed.
- Three active slots plus fire -> no spawn and no fireAccepted. Fire again within 8 frames of an accepted fire -> rejected. Fire at frame 9 with a free slot -> accepted into the lowest free index.
- Slots 0 and 2 entering enemy cells on the same tick -> two hitValid pulses on consecutive cycles, slot 0 reported first.
- fireColor=0 or blockieee=11 -> rejected. rstN low during CHECK1 -> all outputs 0 immediately, and the FSM resumes in IDLE after release.
